if_stage: RTL and testbench

- Instruction-fetch stage of the ARM pipeline.
- Owns the program counter and drives the byte address into the combinational instruction memory.
- Captures the returned 32-bit word, together with PC+4, into the IF/ID pipeline register consumed by decode.
- Handles hazard freeze, branch redirect and flush, flags fetches outside the populated instruction ROM, and counts delivered instructions.

---
 rtl/if_stage.sv | 94 +++++++++
 tb/tb_if_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: program counter, IF/ID register, ROM range fault, delivered count
module if_stage #(
    parameter int MEM_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [31:0]      branch_addr,
    input  logic             flush,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      imem_addr,
    output logic [31:0]      if_pc_plus4,
    output logic [31:0]      if_instr,
    output logic             if_valid,
    output logic             fetch_fault,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [31:0] ROM_LIMIT = 32'(MEM_BYTES);

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_plus4;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        // A taken branch redirects even during a hazard stall.
        if (branch_taken) begin
            pc_d = {branch_addr[31:2], 2'b00};
        end else if (!freeze) begin
            pc_d = pc_plus4;
        end

        if (branch_taken || flush) begin
            pc4_d   = 32'd0;
            instr_d = 32'd0;
            valid_d = 1'b0;
        end else if (!freeze) begin
            if (pc_q >= ROM_LIMIT) begin
                pc4_d   = 32'd0;
                instr_d = 32'd0;
                valid_d = 1'b0;
                fault_d = 1'b1;
            end else begin
                pc4_d   = pc_plus4;
                instr_d = imem_instr;
                valid_d = 1'b1;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= 32'd0;
            pc4_q   <= 32'd0;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_pc_plus4 = pc4_q;
    assign if_instr    = instr_q;
    assign if_valid    = valid_q;
    assign fetch_fault = fault_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with a small counter width to reach saturation
module tb_if_stage;

    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             freeze = 1'b0;
    logic             branch_taken = 1'b0;
    logic [31:0]      branch_addr = 32'd0;
    logic             flush = 1'b0;
    logic [31:0]      imem_instr;
    logic [31:0]      imem_addr;
    logic [31:0]      if_pc_plus4;
    logic [31:0]      if_instr;
    logic             if_valid;
    logic             fetch_fault;
    logic [CNT_W-1:0] fetch_count;

    int checks = 0;
    int errors = 0;

    if_stage #(.MEM_BYTES(1024), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .flush(flush), .imem_instr(imem_instr),
        .imem_addr(imem_addr), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
        .if_valid(if_valid), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // ROM contents: a recognisable tag in the upper half, the byte address in the lower half
    function automatic logic [31:0] rom(input logic [31:0] a);
        return {16'hE1A0, a[15:0]};
    endfunction

    assign imem_instr = rom(imem_addr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, 32'd0); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp %h", if_instr, 32'd0); end
        checks++; if (if_pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pc4 got %h exp %h", if_pc_plus4, 32'd0); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", fetch_fault); end
        checks++; if (fetch_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (if_instr !== rom(32'(4*i))) begin errors++; $display("FAIL seq_instr[%0d] got %h exp %h", i, if_instr, rom(32'(4*i))); end
            checks++; if (if_pc_plus4 !== 32'(4*i+4)) begin errors++; $display("FAIL seq_pc4[%0d] got %h exp %h", i, if_pc_plus4, 32'(4*i+4)); end
            checks++; if (imem_addr !== 32'(4*i+4)) begin errors++; $display("FAIL seq_addr[%0d] got %h exp %h", i, imem_addr, 32'(4*i+4)); end
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b exp 1", i, if_valid); end
            checks++; if (fetch_count !== 3'(i+1)) begin errors++; $display("FAIL seq_count[%0d] got %0d exp %0d", i, fetch_count, i+1); end
        end
    endtask

    task automatic test_freeze();
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL frz_addr[%0d] got %h exp %h", i, imem_addr, 32'h10); end
            checks++; if (if_instr !== rom(32'hC)) begin errors++; $display("FAIL frz_instr[%0d] got %h exp %h", i, if_instr, rom(32'hC)); end
            checks++; if (if_pc_plus4 !== 32'h10) begin errors++; $display("FAIL frz_pc4[%0d] got %h exp %h", i, if_pc_plus4, 32'h10); end
            checks++; if (fetch_count !== 3'd4) begin errors++; $display("FAIL frz_count[%0d] got %0d exp 4", i, fetch_count); end
        end
        freeze = 1'b0;
        step();
        checks++; if (if_instr !== rom(32'h10)) begin errors++; $display("FAIL frz_resume_instr got %h exp %h", if_instr, rom(32'h10)); end
        checks++; if (if_pc_plus4 !== 32'h14) begin errors++; $display("FAIL frz_resume_pc4 got %h exp %h", if_pc_plus4, 32'h14); end
        checks++; if (fetch_count !== 3'd5) begin errors++; $display("FAIL frz_resume_count got %0d exp 5", fetch_count); end
    endtask

    task automatic test_branch_over_freeze();
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h2F;
        step();
        checks++; if (imem_addr !== 32'h2C) begin errors++; $display("FAIL br_addr got %h exp %h", imem_addr, 32'h2C); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL br_instr got %h exp 0", if_instr); end
        checks++; if (if_pc_plus4 !== 32'd0) begin errors++; $display("FAIL br_pc4 got %h exp 0", if_pc_plus4); end
        checks++; if (fetch_count !== 3'd5) begin errors++; $display("FAIL br_count got %0d exp 5", fetch_count); end
        freeze = 1'b0; branch_taken = 1'b0;
        step();
        checks++; if (if_instr !== rom(32'h2C)) begin errors++; $display("FAIL br_tgt_instr got %h exp %h", if_instr, rom(32'h2C)); end
        checks++; if (if_pc_plus4 !== 32'h30) begin errors++; $display("FAIL br_tgt_pc4 got %h exp %h", if_pc_plus4, 32'h30); end
        checks++; if (fetch_count !== 3'd6) begin errors++; $display("FAIL br_tgt_count got %0d exp 6", fetch_count); end
    endtask

    task automatic test_flush();
        branch_taken = 1'b1; branch_addr = 32'h10;
        step();
        branch_taken = 1'b0; flush = 1'b1;
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL fl_instr got %h exp 0", if_instr); end
        checks++; if (imem_addr !== 32'h14) begin errors++; $display("FAIL fl_addr got %h exp %h", imem_addr, 32'h14); end
        checks++; if (fetch_count !== 3'd6) begin errors++; $display("FAIL fl_count got %0d exp 6", fetch_count); end
        flush = 1'b0;
        step();
        checks++; if (if_instr !== rom(32'h14)) begin errors++; $display("FAIL fl_next_instr got %h exp %h", if_instr, rom(32'h14)); end
        checks++; if (fetch_count !== 3'd7) begin errors++; $display("FAIL fl_next_count got %0d exp 7", fetch_count); end
    endtask

    task automatic test_async_reset();
        freeze = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL ar_addr got %h exp 0", imem_addr); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL ar_instr got %h exp 0", if_instr); end
        checks++; if (if_pc_plus4 !== 32'd0) begin errors++; $display("FAIL ar_pc4 got %h exp 0", if_pc_plus4); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", if_valid); end
        checks++; if (fetch_count !== 3'd0) begin errors++; $display("FAIL ar_count got %0d exp 0", fetch_count); end
        #2 rst_n = 1'b1; freeze = 1'b0;
        step();
        checks++; if (if_instr !== rom(32'd0)) begin errors++; $display("FAIL ar_restart_instr got %h exp %h", if_instr, rom(32'd0)); end
        checks++; if (if_pc_plus4 !== 32'd4) begin errors++; $display("FAIL ar_restart_pc4 got %h exp 4", if_pc_plus4); end
        checks++; if (fetch_count !== 3'd1) begin errors++; $display("FAIL ar_restart_count got %0d exp 1", fetch_count); end
    endtask

    task automatic test_flush_freeze();
        flush = 1'b1; freeze = 1'b1;
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ff_valid got %b exp 0", if_valid); end
        checks++; if (imem_addr !== 32'd4) begin errors++; $display("FAIL ff_addr got %h exp 4", imem_addr); end
        checks++; if (fetch_count !== 3'd1) begin errors++; $display("FAIL ff_count got %0d exp 1", fetch_count); end
        flush = 1'b0; freeze = 1'b0;
        step();
        checks++; if (if_instr !== rom(32'd4)) begin errors++; $display("FAIL ff_next_instr got %h exp %h", if_instr, rom(32'd4)); end
        checks++; if (fetch_count !== 3'd2) begin errors++; $display("FAIL ff_next_count got %0d exp 2", fetch_count); end
    endtask

    task automatic test_fault();
        branch_taken = 1'b1; branch_addr = 32'h3FC;
        step();
        branch_taken = 1'b0;
        step();
        checks++; if (if_instr !== rom(32'h3FC)) begin errors++; $display("FAIL ft_last_instr got %h exp %h", if_instr, rom(32'h3FC)); end
        checks++; if (if_pc_plus4 !== 32'h400) begin errors++; $display("FAIL ft_last_pc4 got %h exp %h", if_pc_plus4, 32'h400); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL ft_pre_fault got %b exp 0", fetch_fault); end
        checks++; if (fetch_count !== 3'd3) begin errors++; $display("FAIL ft_last_count got %0d exp 3", fetch_count); end
        step();
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ft_valid got %b exp 0", if_valid); end
        checks++; if (if_instr !== 32'd0) begin errors++; $display("FAIL ft_instr got %h exp 0", if_instr); end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL ft_fault got %b exp 1", fetch_fault); end
        checks++; if (imem_addr !== 32'h404) begin errors++; $display("FAIL ft_addr got %h exp %h", imem_addr, 32'h404); end
        checks++; if (fetch_count !== 3'd3) begin errors++; $display("FAIL ft_count got %0d exp 3", fetch_count); end
        branch_taken = 1'b1; branch_addr = 32'd0;
        step();
        branch_taken = 1'b0;
        step();
        checks++; if (if_instr !== rom(32'd0)) begin errors++; $display("FAIL ft_back_instr got %h exp %h", if_instr, rom(32'd0)); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL ft_back_valid got %b exp 1", if_valid); end
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL ft_sticky got %b exp 1", fetch_fault); end
        checks++; if (fetch_count !== 3'd4) begin errors++; $display("FAIL ft_back_count got %0d exp 4", fetch_count); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (fetch_count !== ((i < 3) ? 3'(5+i) : 3'd7)) begin errors++; $display("FAIL sat_count[%0d] got %0d exp %0d", i, fetch_count, (i < 3) ? 5+i : 7); end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_freeze();
        test_branch_over_freeze();
        test_flush();
        test_async_reset();
        test_flush_freeze();
        test_fault();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
